// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding req/gnt/rvalid to APB3 initiator with per-transfer ACCESS timeout
module apb_req_master #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic                      pwrite,
    output logic                      psel,
    output logic                      penable,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pready,
    input  logic                      pslverr
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic                      pwrite_q, pwrite_d, rvalid_q, rvalid_d, err_q, err_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        pwrite_d = pwrite_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        gnt_o    = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    paddr_d  = addr_i;
                    pwdata_d = wdata_i;
                    pwrite_d = we_i;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    rvalid_d = 1'b1;
                    rdata_d  = pwrite_q ? '0 : prdata;
                    err_d    = pslverr;
                    state_d  = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == LAST) begin
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = cnt_q != '1 ? cnt_q + 1'b1 : cnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_d;
        end
    end

    assign psel     = state_q != IDLE;
    assign penable  = state_q == ACCESS;
    assign paddr    = paddr_q;
    assign pwdata   = pwdata_q;
    assign pwrite   = pwrite_q;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
endmodule

// File: tb/tb_apb_req_master.sv
// tb_apb_req_master: directed scoreboard bench for apb_req_master (timeout 4 and timeout-disabled instances)
module tb_apb_req_master;
    logic        clk = 1'b0, rst_n;
    logic        req, we, pready, pslverr;
    logic [31:0] addr, wdata, prdata;
    logic        gnt_o, rvalid_o, err_o, pwrite, psel, penable;
    logic [31:0] rdata_o, paddr, pwdata;

    logic        req0, pready0;
    logic        gnt0, rvalid0, err0, pwrite0, psel0, penable0;
    logic [31:0] rdata0, paddr0, pwdata0;

    typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
    exp_t sb[$];
    exp_t e;
    int n_chk = 0, n_pass = 0, n_fail = 0;

    apb_req_master #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .addr_i(addr), .we_i(we), .wdata_i(wdata),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_req_master #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req0), .addr_i(32'h1A10_5000), .we_i(1'b0), .wdata_i(32'h0),
        .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0),
        .paddr(paddr0), .pwdata(pwdata0), .pwrite(pwrite0), .psel(psel0), .penable(penable0),
        .prdata(32'h0BAD_0BAD), .pready(pready0), .pslverr(1'b0)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"}, rdata_o, e.rdata);
            chk({tag, "_err"}, 32'(err_o), 32'(e.err));
        end
    endtask

    // entered at a negedge with the DUT idle; returns at the negedge of the rvalid cycle
    task automatic xfer(input string tag, input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int waits, input logic [31:0] pd, input logic se);
        req = 1'b1; addr = a; we = w; wdata = wd; prdata = pd; pslverr = ~se; pready = 1'b1;
        sb.push_back(exp_t'{w ? 32'h0 : pd, se});
        #1 chk({tag, "_gnt"}, 32'(gnt_o), 32'd1);
        @(negedge clk);
        req = 1'b0; addr = ~a; we = ~w; wdata = ~wd;
        chk({tag, "_setup"}, {30'd0, psel, penable}, 32'b10);
        chk({tag, "_setup_gnt"}, 32'(gnt_o), 32'd0);
        chk({tag, "_setup_paddr"}, paddr, a);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            chk({tag, "_access"}, {30'd0, psel, penable}, 32'b11);
            chk({tag, "_paddr"}, paddr, a);
            chk({tag, "_pwdata"}, pwdata, wd);
            chk({tag, "_pwrite"}, 32'(pwrite), 32'(w));
            chk({tag, "_no_rvalid"}, 32'(rvalid_o), 32'd0);
            pready = (i == waits);
            pslverr = (i == waits) ? se : ~se;
        end
        @(negedge clk);
        pready = 1'b0; pslverr = 1'b0;
        chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
        chk({tag, "_idle_psel"}, 32'(psel), 32'd0);
        pop_chk(tag);
    endtask

    initial begin
        int n, rv;
        rst_n = 1'b0; req = 1'b1; prdata = 32'hFFFF_FFFF; pready = 1'b1; pslverr = 1'b1;
        addr = 32'h1A10_1000; we = 1'b0; wdata = 32'h0;
        req0 = 1'b0; pready0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_psel_penable", {30'd0, psel, penable}, 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        rst_n = 1'b1;

        xfer("rd0", 32'h1A10_1000, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
        xfer("wr3", 32'h1A10_3004, 1'b1, 32'h0000_00A5, 3, 32'h5555_5555, 1'b0);
        chk("hold_rdata", rdata_o, 32'h0);
        @(negedge clk);
        chk("rvalid_one_cycle", 32'(rvalid_o), 32'd0);
        chk("hold_paddr_idle", paddr, 32'h1A10_3004);
        xfer("slverr", 32'h1A10_8000, 1'b0, 32'h0, 0, 32'h1234_5678, 1'b1);
        xfer("b2b_rd", 32'h1A10_6008, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        xfer("b2b_wr", 32'h1A10_7000, 1'b1, 32'hA5A5_5A5A, 1, 32'h7777_7777, 1'b1);

        // pready stuck low: abort after exactly 4 ACCESS cycles
        @(negedge clk);
        req = 1'b1; addr = 32'h1A10_2000; we = 1'b0; pready = 1'b0; prdata = 32'hFFFF_0000;
        sb.push_back(exp_t'{32'h0, 1'b1});
        @(negedge clk);
        req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            if (penable) n++;
        end while (penable && n < 20);
        chk("tmo_len", 32'(n), 32'd4);
        chk("tmo_psel", 32'(psel), 32'd0);
        chk("tmo_rvalid", 32'(rvalid_o), 32'd1);
        pop_chk("tmo");

        // timeout disabled: stays in ACCESS
        req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        n = 0; rv = 0;
        repeat (1000) begin
            if (penable0) n++;
            if (rvalid0) rv++;
            @(negedge clk);
        end
        chk("notmo_access", 32'(n), 32'd1000);
        chk("notmo_rvalid", 32'(rv), 32'd0);

        // reset during ACCESS
        req = 1'b1; addr = 32'h1A10_4000; we = 1'b1; wdata = 32'h1111_2222; pready = 1'b0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        chk("mid_access", 32'(penable), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_psel_penable", {30'd0, psel, penable}, 32'd0);
        chk("mid_rst_paddr", paddr, 32'd0);
        chk("mid_rst_access0", 32'(penable0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rv = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid_o) rv++;
        end
        chk("mid_rst_no_rvalid", 32'(rv), 32'd0);
        xfer("post_rst", 32'h1A10_9000, 1'b0, 32'h0, 1, 32'h0F0F_F0F0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
